gray_code_decoder: RTL and testbench
====================================

GRAY_CODE_DECODER -- requirements
Module: gray_code_decoder

Interface
REQ-001 Parameter WIDTH, default 4: code word width in bits, legal range 2..16.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port gc_in, input, WIDTH: Gray-coded input word.
REQ-005 Port in_valid, input, 1: gc_in is valid this cycle.
REQ-006 Port in_ready, output, 1: block accepts gc_in this cycle.
REQ-007 Port bin_out, output, WIDTH: decoded binary word.
REQ-008 Port out_valid, output, 1: bin_out is valid.
REQ-009 Port out_ready, input, 1: downstream accepts bin_out.
REQ-010 Port word_count, output, 16: count of completed output handshakes.
REQ-011 Port step_err, output, 1: sticky Gray step violation flag; present only with GRAY_STEP_CHECK_EN.

Function
REQ-012 The input handshake occurs when in_valid and in_ready are both high; the output handshake occurs when out_valid and out_ready are both high.
REQ-013 Stage 1 shall register gc_in on each input handshake.
REQ-014 Stage 2 shall register the decoded value of the stage-1 word: b[WIDTH-1] = g[WIDTH-1], and b[i] = b[i+1] XOR g[i] for i descending to 0.
REQ-015 Latency shall be exactly 2 cycles from the input handshake to out_valid, with no backpressure.
REQ-016 Throughput shall be one word per cycle while out_ready is held high.
REQ-017 Each stage shall hold a valid flag; a stage advances when its successor is empty or is being emptied in the same cycle.
REQ-018 in_ready shall equal NOT s1_valid OR stage-1 advance; it is combinational and has no dependency on in_valid.
REQ-019 While out_valid is high and out_ready is low, bin_out and out_valid shall hold stable.
REQ-020 A simultaneous input and output handshake on full stages shall lose and duplicate no word.
REQ-021 Words shall leave in acceptance order; no reordering is allowed.
REQ-022 word_count shall increment by 1 on each output handshake and wrap from 0xFFFF to 0x0000.

Reset
REQ-023 When rst is high at a clock edge, s1_valid, out_valid, bin_out, word_count, and step_err shall become 0.
REQ-024 With rst high, in_ready shall be 0; it shall be 1 on the first cycle after rst deasserts.
REQ-025 Reset mid-operation shall discard in-flight words; no output handshake shall occur on the reset cycle.
REQ-026 Reset shall clear the step-checker reference, so the first word after reset is unchecked.

Configuration
REQ-027 With macro GRAY_STEP_CHECK_EN defined, each accepted gc_in shall be compared with the previously accepted word.
REQ-028 With the macro defined, if the XOR of the two words has more than one bit set, step_err shall set 1 cycle after acceptance.
REQ-029 With the macro defined, step_err stays set until reset; repeated identical words (XOR = 0) are legal.
REQ-030 Without the macro, the step_err port, the reference register, and the compare logic shall be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then gc_in=4'b0110 with in_valid=1 and out_ready=1 -> bin_out=4'b0100, out_valid=1 exactly 2 cycles later, word_count=1.
REQ-032 Stream Gray codes of 0..15 back-to-back with out_ready=1 -> bin_out = 0..15 on 16 consecutive cycles; 1000 -> 1111, 1111 -> 1010; word_count=16.
REQ-033 out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 words are buffered; bin_out held stable; on out_ready=1, order is intact with no loss or duplication.
REQ-034 Drive 0xFFFF output handshakes, then 2 more -> word_count reads 0xFFFF, then 0x0000, then 0x0001.
REQ-035 GRAY_STEP_CHECK_EN: 0110 -> 0111 leaves step_err=0; then 0111 -> 0001 (two bits change) sets step_err=1, which persists until rst; the first word after rst never sets it.
REQ-036 Assert rst with 2 words in flight -> out_valid=0 on the next cycle, neither word is ever emitted, and word_count=0.

Source files
------------

// File: rtl/gray_code_decoder.sv
// Two-stage valid/ready pipeline that converts Gray-coded words to binary and counts delivered words.
// Optional macro GRAY_STEP_CHECK_EN adds a sticky step_err flag for accepted words differing in more than one bit.
module gray_code_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gc_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      word_count
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_word;
  logic             s2_valid;
  logic [WIDTH-1:0] decoded;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_hs;
  logic             out_hs;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign decoded = gray_to_bin(s1_word);

  // Reset masks both handshake signals so nothing is accepted or delivered on a reset cycle.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !rst && (!s1_valid || s2_adv);
  assign out_valid = s2_valid && !rst;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_word    <= '0;
      s2_valid   <= 1'b0;
      bin_out    <= '0;
      word_count <= '0;
    end else begin
      if (in_hs) begin
        s1_word  <= gc_in;
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        bin_out  <= decoded;
        s2_valid <= 1'b1;
      end else if (out_hs) begin
        s2_valid <= 1'b0;
      end
      if (out_hs) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] ref_word;
  logic             ref_valid;
  logic [WIDTH-1:0] step_diff;
  logic             multi_bit;

  // Clearing the lowest set bit leaves something only if two or more bits changed.
  assign step_diff = gc_in ^ ref_word;
  assign multi_bit = |(step_diff & (step_diff - {{(WIDTH-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_word  <= '0;
      ref_valid <= 1'b0;
      step_err  <= 1'b0;
    end else if (in_hs) begin
      if (ref_valid && multi_bit) begin
        step_err <= 1'b1;
      end
      ref_word  <= gc_in;
      ref_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_code_decoder.sv
// Randomized and directed bench for gray_code_decoder, scored against a queue-based reference model.
module tb_gray_code_decoder;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] gc_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bin_out;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      word_count;
`ifdef GRAY_STEP_CHECK_EN
  logic             step_err;
`endif

  always #5 clk = ~clk;

  gray_code_decoder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .gc_in      (gc_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin_out    (bin_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count)
`ifdef GRAY_STEP_CHECK_EN
    ,
    .step_err   (step_err)
`endif
  );

  typedef struct {
    int bin;
    int edge_no;
  } entry_t;

  entry_t exp_q[$];
  int     cyc;
  int     model_count;
  int     checks;
  int     passed;
  bit     prev_rst;
  bit     model_err;
  bit     ref_valid;
  int     ref_word;

  // Binary value is the XOR of the Gray word with all of its right shifts.
  function automatic int gray2bin(input int g);
    int b;
    b = 0;
    for (int s = 0; s < WIDTH; s++) b ^= (g >> s);
    return b & MASK;
  endfunction

  function automatic int bin2gray(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive at the falling edge, check settled outputs, then advance the model at the rising edge.
  task automatic applyStimulus(input bit r, input bit v, input int g, input bit ordy);
    bit     exp_ir;
    bit     exp_ov;
    bit     in_hs;
    bit     out_hs;
    entry_t e;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    gc_in     = g[WIDTH-1:0];
    out_ready = ordy;
    #1;
    exp_ir = !r && (exp_q.size() < 2 || ordy);
    exp_ov = !r && exp_q.size() > 0 && exp_q[0].edge_no < cyc;
    checkOutput("in_ready", in_ready, exp_ir);
    checkOutput("out_valid", out_valid, exp_ov);
    if (exp_ov) checkOutput("bin_out", bin_out, exp_q[0].bin);
    if (prev_rst) checkOutput("bin_out_reset", bin_out, 0);
    checkOutput("word_count", word_count, model_count);
`ifdef GRAY_STEP_CHECK_EN
    checkOutput("step_err", step_err, model_err);
`endif
    in_hs  = exp_ir && v;
    out_hs = exp_ov && ordy;
    @(posedge clk);
    cyc++;
    prev_rst = r;
    if (r) begin
      exp_q.delete();
      model_count = 0;
      model_err   = 0;
      ref_valid   = 0;
    end else begin
      if (out_hs) begin
        e = exp_q.pop_front();
        model_count = (model_count + 1) % 65536;
      end
      if (in_hs) begin
        e.bin     = gray2bin(g & MASK);
        e.edge_no = cyc;
        exp_q.push_back(e);
        if (ref_valid && $countones((g ^ ref_word) & MASK) > 1) model_err = 1;
        ref_word  = g & MASK;
        ref_valid = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; gc_in = '0; out_ready = 1'b0;
    cyc = 0; model_count = 0; checks = 0; passed = 0; prev_rst = 0;
    model_err = 0; ref_valid = 0; ref_word = 0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    // Single word 0110 decodes to 0100 two cycles after acceptance.
    applyStimulus(0, 1, 'b0110, 1);
    idle(3);
    #1 checkOutput("single_word_count", word_count, 1);

    applyStimulus(1, 0, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, bin2gray(i), 1);
    idle(3);
    #1 checkOutput("stream16_count", word_count, 16);

    // Step checker: one-bit change is legal, two-bit change is flagged until reset.
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 'b0110, 1);
    applyStimulus(0, 1, 'b0111, 1);
    idle(1);
`ifdef GRAY_STEP_CHECK_EN
    #1 checkOutput("step_single_bit", step_err, 0);
`endif
    applyStimulus(0, 1, 'b0001, 1);
    idle(3);
`ifdef GRAY_STEP_CHECK_EN
    #1 checkOutput("step_two_bits", step_err, 1);
`endif
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 'b1111, 1);
    idle(2);
`ifdef GRAY_STEP_CHECK_EN
    #1 checkOutput("step_after_reset", step_err, 0);
`endif

    // Backpressure for 5 cycles mid-stream.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, bin2gray(i), !(i >= 2 && i < 7));
    idle(3);

    // Reset with two words in flight discards both.
    applyStimulus(0, 1, 'b0011, 1);
    applyStimulus(0, 1, 'b0010, 1);
    applyStimulus(1, 0, 0, 1);
    idle(3);
    #1 checkOutput("flush_count", word_count, 0);

    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, MASK),
                    $urandom_range(0, 3) != 0);
    idle(3);

    // Counter wrap at 16 bits.
    applyStimulus(1, 0, 0, 1);
    for (int i = 0; i < 65535; i++) applyStimulus(0, 1, $urandom_range(0, MASK), 1);
    idle(3);
    #1 checkOutput("count_ffff", word_count, 16'hFFFF);
    applyStimulus(0, 1, 'b0101, 1);
    idle(3);
    #1 checkOutput("count_wrap_0", word_count, 16'h0000);
    applyStimulus(0, 1, 'b0100, 1);
    idle(3);
    #1 checkOutput("count_wrap_1", word_count, 16'h0001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
